// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults and the receiver state encoding.
// Both the transmitter and the receiver import this package.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 234;  // round(27 MHz / 115 200)
    localparam int unsigned CNT_W        = 8;    // must hold CLKS_PER_BIT-1
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side interface of the UART receiver: holding register, read strobe, status.
// The receiver takes the master modport, the reading host the slave modport.
interface uart_rx_if;
    import uart_pkg::*;

    logic              i_re;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_frame_err;
    logic              o_overrun;

    modport master (
        input  i_re,
        output o_data, o_valid, o_busy, o_frame_err, o_overrun
    );

    modport slave (
        output i_re,
        input  o_data, o_valid, o_busy, o_frame_err, o_overrun
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a delay flop for
// falling-edge detection. Everything resets to the idle (high) line level.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_d;

    // NOTE: non-blocking assignments make each flop take the value its neighbour
    // held before the edge, which is what turns three statements into a shift chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-bit glitch rejection, one-entry
// holding register with valid/read handshake, framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned D = CLKS_PER_BIT,
    parameter int unsigned L = CNT_W
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_rx,
    uart_rx_if.master bus
);

    localparam logic [L-1:0] CNT_HALF = L'(D / 2 - 1);
    localparam logic [L-1:0] CNT_LAST = L'(D - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [L-1:0]      cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              rx_s;
    logic              rx_fall;

    logic              busy;
    logic              bit_tick;
    logic              stop_tick;
    logic              cnt_clr;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overrun_q;
    logic              ferr_q;
    logic              load;
    logic              accept;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .rx_s    (rx_s),
        .fall    (rx_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: giving state_nxt a default before the case keeps every path assigned,
    // so no latch is inferred when a branch has nothing to change.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (rx_fall) state_nxt = START;
            START: if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        bit_tick  = (state == DATA) && (cnt == CNT_LAST);
        stop_tick = (state == STOP) && (cnt == CNT_LAST);
        cnt_clr   = (state == IDLE) || (state_nxt != state) || bit_tick;
    end

    // Counter restarts on every state change and after each data sample, so the
    // compare bounds are always reached before it could wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + L'(1);
            if (state == IDLE) bit_idx <= '0;
            else if (bit_tick) bit_idx <= bit_idx + 3'd1;
            if (bit_tick) shift <= {rx_s, shift[DATA_W-1:1]};
        end
    end

    assign load   = stop_tick & rx_s;
    assign accept = bus.i_re & valid_q;

    // A read coinciding with a load consumes the old byte, so it is not an overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ferr_q <= stop_tick & ~rx_s;
            if (load) begin
                data_q    <= shift;
                valid_q   <= 1'b1;
                overrun_q <= accept ? 1'b0 : (overrun_q | valid_q);
            end else if (accept) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_busy      = busy;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus
// random frames, compared against a frame-level model of the holding register.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int D = CLKS_PER_BIT;
    // Start bit driven just after edge P0; rx_s sees it two edges later (E = P0+2),
    // outputs update at E + D/2 + 9*D + 1.
    localparam int LOAD_K = 2 + HALF_BIT + 9 * D + 1;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.D(D), .L(CNT_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of what the host should see
    logic       m_valid   = 1'b0;
    logic [7:0] m_data    = 8'h00;
    logic       m_overrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_host(input string tag);
        check({tag, "_valid"},   bus.o_valid,   m_valid);
        check({tag, "_data"},    bus.o_data,    m_data);
        check({tag, "_overrun"}, bus.o_overrun, m_overrun);
    endtask

    task automatic model_read();
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    // Drive one full 10-bit frame; checks sit at the cycles where the spec pins behaviour.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic re_on_load,
                             input logic read_next, input int abort_k);
        logic [9:0] frame;
        logic       aborted;
        frame   = {stop_bit, b, 1'b0};
        aborted = 1'b0;
        for (int k = 0; k < 10 * D && !aborted; k++) begin
            i_rx = frame[k / D];
            if (k == 2) check("busy_before_edge", bus.o_busy, 1'b0);
            if (k == 3) check("busy_after_edge", bus.o_busy, 1'b1);
            if (k == abort_k) begin
                i_rst_n = 1'b0;
                #1;
                m_valid = 1'b0; m_data = 8'h00; m_overrun = 1'b0;
                check_host("abort");
                check("abort_busy", bus.o_busy, 1'b0);
                check("abort_ferr", bus.o_frame_err, 1'b0);
                i_rx = 1'b1;
                step();
                step();
                i_rst_n = 1'b1;
                aborted = 1'b1;
            end
            if (k == LOAD_K - 1) begin
                check_host("pre_load");
                check("pre_load_ferr", bus.o_frame_err, 1'b0);
                check("pre_load_busy", bus.o_busy, 1'b1);
                bus.i_re = re_on_load;
            end
            if (k == LOAD_K) begin
                bus.i_re = 1'b0;
                if (stop_bit) begin
                    // An unread byte being replaced is an overrun unless it is read right now
                    if (m_valid && !re_on_load) m_overrun = 1'b1;
                    else if (m_valid && re_on_load) m_overrun = 1'b0;
                    m_valid = 1'b1;
                    m_data  = b;
                end else if (re_on_load) begin
                    model_read();
                end
                check_host("load");
                check("load_ferr", bus.o_frame_err, !stop_bit);
                check("load_busy", bus.o_busy, 1'b0);
                bus.i_re = read_next;
            end
            if (k == LOAD_K + 1) begin
                check("ferr_one_cycle", bus.o_frame_err, 1'b0);
                if (read_next) begin
                    bus.i_re = 1'b0;
                    model_read();
                    check_host("read_next");
                end
            end
            if (!aborted) step();
        end
    endtask

    task automatic read_byte(input string tag);
        bus.i_re = 1'b1;
        step();
        bus.i_re = 1'b0;
        model_read();
        check_host(tag);
    endtask

    initial begin
        logic       seen;
        logic [7:0] b;
        logic       stop_b, rol, rn;

        bus.i_re = 1'b0;
        repeat (3) step();
        i_rst_n = 1'b1;
        step();
        check_host("reset");
        check("reset_busy", bus.o_busy, 1'b0);
        check("reset_ferr", bus.o_frame_err, 1'b0);

        seen = 1'b0;
        for (int k = 0; k < 10 * D; k++) begin
            seen |= bus.o_busy;
            step();
        end
        check("idle_busy", seen, 1'b0);

        send_byte(8'hA5, 1'b1, 1'b0, 1'b1, -1);

        // Short low glitch must be rejected at the start-bit sample
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            i_rx = (k < 50) ? 1'b0 : 1'b1;
            if (k == 3) check("glitch_busy", bus.o_busy, 1'b1);
            if (k == HALF_BIT + 2) check("glitch_busy_hold", bus.o_busy, 1'b1);
            if (k == HALF_BIT + 3) begin
                check("glitch_idle", bus.o_busy, 1'b0);
                check_host("glitch");
            end
            seen |= bus.o_frame_err;
            step();
        end
        check("glitch_ferr", seen, 1'b0);

        // Framing error followed by a break: no new frame while the line stays low
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        seen = 1'b0;
        for (int k = 0; k < 3 * D; k++) begin
            seen |= bus.o_busy;
            step();
        end
        check("break_busy", seen, 1'b0);
        i_rx = 1'b1;
        repeat (5) step();
        check("break_recover_busy", bus.o_busy, 1'b0);

        send_byte(8'h11, 1'b1, 1'b0, 1'b0, -1);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0, -1);
        check("b2b_overrun", bus.o_overrun, 1'b1);
        read_byte("b2b_read");

        send_byte(8'h11, 1'b1, 1'b0, 1'b0, -1);
        send_byte(8'h22, 1'b1, 1'b1, 1'b0, -1);
        check("coinc_overrun", bus.o_overrun, 1'b0);
        read_byte("coinc_read");
        read_byte("empty_read");

        send_byte(8'hFF, 1'b1, 1'b0, 1'b0, 1000);
        repeat (10) step();
        check_host("post_abort");
        send_byte(8'h55, 1'b1, 1'b0, 1'b0, -1);
        read_byte("after_abort_read");

        for (int n = 0; n < 10; n++) begin
            b      = 8'($urandom);
            stop_b = ($urandom_range(0, 4) != 0);
            rol    = ($urandom_range(0, 3) == 0);
            rn     = ($urandom_range(0, 2) == 0);
            send_byte(b, stop_b, rol, rn, -1);
            i_rx = 1'b1;
            repeat ($urandom_range(3, 40)) step();
        end
        check_host("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of the team's UART transmitter. It runs at the same bit timing, 115 200 bit/s from a 27 MHz clock. It synchronises the asynchronous serial line, detects and qualifies start bits, and samples each bit at mid-period. Good bytes go into a one-entry holding register that the host reads with a valid/read handshake; framing and overrun errors are flagged.

## Interface
- D, 234: clock cycles per bit, round(27 MHz / 115 200).
- L, 8: bit-period counter width; must hold D-1.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_re  in  1  read strobe; consumes the held byte when o_valid=1.
- o_data  out  8  received byte, held until replaced.
- o_valid  out  1  holding register contains an unread byte.
- o_busy  out  1  frame reception in progress (state != IDLE).
- o_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- o_overrun  out  1  sticky: an unread byte was overwritten; cleared by an accepted i_re.

## Operation
- Synchroniser: two flops on i_rx give rx_s. A third flop gives rx_d. All three reset to 1.
- Start edge: rx_s=0 and rx_d=1 while in IDLE.
- States:
  - IDLE: on start edge go to START; counter=0, bit index=0.
  - START: at counter D/2-1 (integer D/2, i.e. 117), sample rx_s. If 1 (glitch), go to IDLE, no flags. If 0, go to DATA with counter=0.
  - DATA: at counter D-1, sample rx_s into the shift register LSB-first and reset the counter. After 8 samples, go to STOP.
  - STOP: at counter D-1, sample rx_s. If 1, load the holding register; if 0, pulse o_frame_err and discard the byte. Go to IDLE in both cases.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be caught.
- Line held low after a frame error (break) produces no new frame until rx_s returns to 1, because IDLE needs a falling edge.
- Holding-register load:
  - o_data gets the byte and o_valid=1.
  - If o_valid was already 1 and i_re is not asserted in that cycle, set o_overrun.
- Read: i_re=1 with o_valid=1 clears o_valid and o_overrun on the next cycle.
  - i_re with o_valid=0 is ignored.
  - Load and i_re in the same cycle: the new byte is loaded, o_valid stays 1, no overrun.
- Counter arithmetic is L-bit and never wraps, because the compare bounds are at most D-1.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_frame_err=0, o_overrun=0. State is IDLE and counters are 0.
- Reset asserted mid-frame aborts immediately with no flags. After release, a new start edge is needed.
- Let E be the cycle in which the start edge is seen; rx_s lags i_rx by 2 cycles.
- o_busy is 1 from cycle E+1.
- Start sample at E+D/2.
- Data bit k (k=0..7) sampled at E+D/2+(k+1)·D.
- Stop sample at E+D/2+9·D.
- o_valid, o_data, o_overrun and o_frame_err update at E+D/2+9·D+1. o_busy returns to 0 in the same cycle.
- With D=234, o_valid rises 2224 cycles after E.
- o_frame_err is high for exactly one cycle.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - default constants for D and L, shared with the transmitter;
  - the half-bit constant D/2.
- Sub-module uart_rx_sync holds the 2-flop synchroniser plus edge-detect flop. Outputs: rx_s and a fall pulse; reset value 1.

## Test plan
- Reset then idle line: all outputs 0 and o_busy stays 0 for 10·D cycles.
- Send 0xA5 with exact 234-cycle bits:
  - o_valid rises E+2224 with o_data=0xA5 and no error flags;
  - i_re one cycle later clears o_valid.
- Low glitch of 50 cycles on an idle line: o_busy pulses high, then returns to IDLE at E+117 with o_valid=0 and no flags.
- Send 0x3C with the stop bit held 0: o_frame_err pulses one cycle at E+2224, o_valid stays 0, and no frame starts until the line goes high.
- Send 0x11 then 0x22 back-to-back with no i_re:
  - o_data=0x22, o_valid=1, o_overrun=1;
  - i_re clears both flags.
  - Repeat with i_re coincident with the second load: o_overrun stays 0.
- Assert i_rst_n low mid-DATA during 0xFF: outputs return to reset values. After release, 0x55 is received correctly.
